// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions for the divider/multiplier pair:
// operand width defaults, sequencer state encoding and counter sizing.
package arith_pkg;

    localparam int unsigned QW_DEF = 8;
    localparam int unsigned DW_DEF = 7;

    // Iteration counter width for a QW-step sequencer (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(QW_DEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/shift_add_step.sv
// One shift-add iteration: conditionally adds the multiplicand shifted by the
// iteration count, and retires the low multiplier bit.
module shift_add_step #(
    parameter int unsigned QW = 8,
    parameter int unsigned PW = 15,
    parameter int unsigned CW = 3
) (
    input  logic [PW-1:0] acc_i,
    input  logic [PW-1:0] mcand_i,
    input  logic [QW-1:0] mplier_i,
    input  logic [CW-1:0] count_i,
    output logic [PW-1:0] acc_o,
    output logic [QW-1:0] mplier_o
);

    // PW bits always suffice: the largest multiply-accumulate result fits.
    always_comb begin
        acc_o    = mplier_i[0] ? (acc_i + (mcand_i << count_i)) : acc_i;
        mplier_o = mplier_i >> 1;
    end

endmodule

// File: rtl/multiplier.sv
// Sequential shift-add multiply-accumulate: product = quotientin*divisorin +
// remainderin, using the divider's start/valid handshake and operand timing.
module multiplier
    import arith_pkg::*;
#(
    parameter int unsigned QW = QW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [QW-1:0]    quotientin,
    input  logic [DW-1:0]    divisorin,
    input  logic [DW-1:0]    remainderin,
    output logic [QW+DW-1:0] product,
    output logic             valid,
    output logic             busy,
    output logic             fits
);

    localparam int unsigned PW = QW + DW;
    localparam int unsigned CW = cnt_width(QW);

    state_e        state_q, state_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [QW-1:0] mplier_q, mplier_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          fits_q, fits_d;

    logic [PW-1:0] step_acc;
    logic [QW-1:0] step_mplier;

    shift_add_step #(
        .QW (QW),
        .PW (PW),
        .CW (CW)
    ) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .count_i  (count_q),
        .acc_o    (step_acc),
        .mplier_o (step_mplier)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            fits_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            fits_q   <= fits_d;
        end
    end

    // Next state and datapath; start overrides every state and restarts.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                mcand_d  = PW'(divisorin);
                mplier_d = quotientin;
                acc_d    = PW'(remainderin);
                count_d  = '0;
                state_d  = S_CALC;
            end
            S_CALC: begin
                acc_d    = step_acc;
                mplier_d = step_mplier;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(QW - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = S_LOAD;
        end

        valid_d = (state_d == S_DONE);
        busy_d  = (state_d == S_LOAD) || (state_d == S_CALC);
        fits_d  = valid_d && (acc_d[PW-1:QW] == '0);
    end

    assign product = acc_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign fits    = fits_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed and divider-loop-back checks for the shift-add multiplier.
module tb_multiplier;

    localparam int unsigned QW = 8;
    localparam int unsigned DW = 7;
    localparam int unsigned PW = QW + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [QW-1:0] quotientin = '0;
    logic [DW-1:0] divisorin = '0;
    logic [DW-1:0] remainderin = '0;
    logic [PW-1:0] product;
    logic          valid;
    logic          busy;
    logic          fits;

    int n_cmp = 0;
    int n_mis = 0;

    multiplier #(.QW(QW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .quotientin  (quotientin),
        .divisorin   (divisorin),
        .remainderin (remainderin),
        .product     (product),
        .valid       (valid),
        .busy        (busy),
        .fits        (fits)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start is sampled on the next edge (edge k); returns just after it.
    task automatic kick();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Operands captured on edge k+1, then scrambled to prove they are ignored.
    task automatic load_ops(input int q, input int d, input int r);
        quotientin  = QW'(q);
        divisorin   = DW'(d);
        remainderin = DW'(r);
        tick(1);
        quotientin  = QW'($urandom);
        divisorin   = DW'($urandom);
        remainderin = DW'($urandom);
    endtask

    task automatic run_op(input string tag, input int q, input int d, input int r,
                          input int exp_p, input int exp_f);
        kick();
        check_eq({tag, " busy@k"}, 32'(busy), 32'd1);
        check_eq({tag, " valid@k"}, 32'(valid), 32'd0);
        load_ops(q, d, r);
        tick(7);
        check_eq({tag, " valid@k+8"}, 32'(valid), 32'd0);
        tick(1);
        check_eq({tag, " valid@k+9"}, 32'(valid), 32'd1);
        check_eq({tag, " busy@k+9"}, 32'(busy), 32'd0);
        check_eq({tag, " product"}, 32'(product), 32'(exp_p));
        check_eq({tag, " fits"}, 32'(fits), 32'(exp_f));
    endtask

    initial begin
        int dividend, divisor, q, r;

        #12;
        check_eq("reset product", 32'(product), 32'd0);
        check_eq("reset valid", 32'(valid), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset fits", 32'(fits), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(2);

        run_op("basic", 12, 10, 3, 123, 1);
        tick(5);
        check_eq("basic hold product", 32'(product), 32'd123);
        check_eq("basic hold valid", 32'(valid), 32'd1);

        run_op("max", 255, 127, 127, 32512, 0);
        run_op("max-1", 255, 127, 126, 32511, 0);
        run_op("zero mplier", 0, 5, 4, 4, 1);
        run_op("zero mcand", 200, 0, 0, 0, 1);

        // Restart while CALC is running: start sampled on edge k+5.
        kick();
        load_ops(12, 10, 3);
        tick(3);
        kick();
        check_eq("restart valid@k'", 32'(valid), 32'd0);
        check_eq("restart busy@k'", 32'(busy), 32'd1);
        load_ops(3, 4, 1);
        tick(7);
        check_eq("restart valid@k'+8", 32'(valid), 32'd0);
        tick(1);
        check_eq("restart valid", 32'(valid), 32'd1);
        check_eq("restart product", 32'(product), 32'd13);

        // Restart from DONE: valid drops on the edge that samples start.
        kick();
        check_eq("done-restart valid drop", 32'(valid), 32'd0);
        check_eq("done-restart fits drop", 32'(fits), 32'd0);
        load_ops(7, 9, 2);
        tick(8);
        check_eq("done-restart product", 32'(product), 32'd65);
        check_eq("done-restart valid", 32'(valid), 32'd1);

        // Asynchronous reset between edges mid-CALC.
        kick();
        load_ops(200, 100, 50);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async rst product", 32'(product), 32'd0);
        check_eq("async rst valid", 32'(valid), 32'd0);
        check_eq("async rst busy", 32'(busy), 32'd0);
        check_eq("async rst fits", 32'(fits), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(12);
        check_eq("post-rst valid", 32'(valid), 32'd0);
        check_eq("post-rst busy", 32'(busy), 32'd0);
        run_op("post-rst op", 200, 100, 50, 20050, 0);

        // Divider loop-back: reconstructed dividend, divider bench timing.
        for (int i = 0; i < 1000; i++) begin
            dividend = int'($urandom_range(0, 255));
            divisor  = int'($urandom_range(1, 127));
            q = dividend / divisor;
            r = dividend % divisor;
            kick();
            load_ops(q, d_fix(divisor), r);
            tick(16);
            check_eq("loopback product", 32'(product), 32'(dividend));
            check_eq("loopback fits", 32'(fits), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    function automatic int d_fix(input int d);
        return d;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multiplier.md
# multiplier

Sequential shift-add multiply-accumulate unit, the inverse companion of the `divider` block. It reconstructs a dividend from a divider result:

- product = quotientin × divisorin + remainderin.
- It uses the same start/valid handshake and operand timing as `divider`, so a `divider` → `multiplier` loop-back can check results on chip and in simulation.
- It sits beside `divider` in the arithmetic datapath and shares its operand widths.

## Interface
- QW, default 8, width of quotientin (multiplier operand).
- DW, default 7, width of divisorin and remainderin.
- PW, derived as QW+DW (15), width of product. Not overridable.
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle pulse that begins an operation.
- quotientin  input  QW  multiplier; sampled one cycle after start.
- divisorin  input  DW  multiplicand; sampled one cycle after start.
- remainderin  input  DW  addend; sampled one cycle after start.
- product  output  PW  accumulated result; meaningful only while valid=1.
- valid  output  1  product complete; held until next start or reset.
- busy  output  1  high in LOAD and CALC.
- fits  output  1  valid result with product[PW-1:QW]==0, i.e. product fits in a QW-bit dividend.

## Operation
- States: IDLE, LOAD, CALC, DONE. Encoding lives in the package.
- IDLE: start=1 → LOAD.
- LOAD (one cycle) registers the operands and clears the counter, then → CALC:
  - mcand ← zero-extended divisorin.
  - mplier ← quotientin.
  - acc ← zero-extended remainderin.
- CALC runs QW iterations. In each iteration:
  - If mplier[0]=1, acc ← acc + (mcand << count), PW-bit add.
  - mplier ← mplier >> 1.
  - count ← count+1.
  - After the iteration with count=QW-1, → DONE.
- DONE: valid=1 and product=acc are held stable; stays in DONE until start.
- start=1 in any state (IDLE, LOAD, CALC, DONE) → LOAD on that edge, which aborts any operation in progress and drops valid. The inputs for the new operation are taken the following edge.
- Arithmetic:
  - Maximum result is (2^QW−1)(2^DW−1)+(2^DW−1) = 2^(QW+DW) − 2^QW = 32512 for default widths. This fits in PW bits, so the accumulator never overflows and no carry-out is kept.
  - fits=valid & (acc[PW-1:QW]==0).
- Zero operands need no special case: quotientin=0 yields product=remainderin; divisorin=0 is legal.
- Reset values: state=IDLE, product=0, valid=0, busy=0, fits=0, with all internal registers zero. Reset asserted mid-CALC aborts immediately; no result appears after release until a new start.

## Timing
- Edge k: start sampled high → LOAD.
- Edge k+1: operands captured. The driver changes operands only after start falls, matching `divider`.
- Edges k+2 … k+QW+1 (k+2 … k+9 by default): the QW CALC iterations.
- Edge k+QW+1 (k+9): enters DONE. valid, product and fits are valid from this edge onward.
- A bench that waits 17 cycles after deasserting start, as for `divider`, sees a stable result.
- busy is high from after edge k through edge k+QW+1, exclusive.
- valid falls on the edge that samples start. There is no cycle with valid=1 and stale product.
- Operand changes after edge k+1 have no effect on the running operation.

## Structure
- Package `arith_pkg` holds:
  - the state enum (IDLE/LOAD/CALC/DONE);
  - the QW/DW defaults;
  - a counter-width constant of $clog2(QW) bits.
- `divider` imports `arith_pkg` too, so both blocks share the widths.
- One natural sub-module: `shift_add_step`, a purely combinational next-acc/next-mplier function of (acc, mcand, mplier, count).
- The top level holds the FSM, counter and registers. Expected size is about 150–200 lines of RTL.

## Test plan
- Basic: start, then quotientin=12, divisorin=10, remainderin=3 → valid rises at k+9 with product=123, fits=1, held until next start.
- Maximum: quotientin=255, divisorin=127, remainderin=127 → product=32512, fits=0. Also quotientin=255, divisorin=127, remainderin=126 → product=32511.
- Zero multiplier: quotientin=0, divisorin=5, remainderin=4 → product=4, fits=1. Zero multiplicand: quotientin=200, divisorin=0, remainderin=0 → product=0.
- Restart: start asserted during CALC (edge k+5) with new operands 3,4,1 → valid stays 0, then product=13 at nine edges after the second start. Start asserted while in DONE → valid drops on that edge.
- Reset mid-CALC: reset asserted asynchronously between edges → all outputs 0 immediately, IDLE after release, and no valid without a new start.
- Loop-back: 1000 random `divider` results fed back with the `divider` bench timing → product equals the original dividend, fits=1, every case.
